// File: rtl/dac_reg_spi_arbiter.sv
// dac_reg_spi_arbiter
// Shares one SPI master between DAC sample traffic (sine generator) and
// configuration writes to the diapason/key shift register. Owns the
// active-low chip-select pair, enforces CS setup/hold/gap timing and issues
// exactly one spi_start per granted transfer.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   sample_valid/sample_data : one-cycle DAC sample strobe and word
//   sample_overrun  : pulse, buffered sample overwritten before it was sent
//   reg_req/reg_data: level config request (held until reg_ack) and word
//   reg_ack         : pulse as CS returns to NONE after a REG transfer
//   spi_start/spi_data : start pulse and word towards spi_master
//   spi_busy/spi_done  : spi_master status and completion pulse
//   cs_dac_reg      : 2'b11 NONE, 2'b01 DAC, 2'b10 REG
//   arb_busy        : high whenever the FSM is not IDLE
//   timeout_err     : pulse, spi_done not seen within TIMEOUT cycles
module dac_reg_spi_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 1,
   parameter int CS_GAP     = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   output logic                  sample_overrun,
   input  logic                  reg_req,
   input  logic [DATA_WIDTH-1:0] reg_data,
   output logic                  reg_ack,
   output logic                  spi_start,
   output logic [DATA_WIDTH-1:0] spi_data,
   input  logic                  spi_busy,
   input  logic                  spi_done,
   output logic [1:0]            cs_dac_reg,
   output logic                  arb_busy,
   output logic                  timeout_err
);

   localparam logic [1:0] CS_NONE = 2'b11;
   localparam logic [1:0] CS_DAC  = 2'b01;
   localparam logic [1:0] CS_REG  = 2'b10;

   localparam logic [7:0] SETUP_LD     = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LD      = 8'(CS_HOLD - 1);
   localparam logic [7:0] GAP_LD       = 8'(CS_GAP - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [1:0]            cs_q, cs_d;
   logic                  spi_start_q, spi_start_d;
   logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;
   logic                  reg_ack_q, reg_ack_d;
   logic                  timeout_q, timeout_d;
   logic                  is_reg_q, is_reg_d;
   logic                  arb_busy_q, arb_busy_d;
   logic [DATA_WIDTH-1:0] sbuf_q, sbuf_d;
   logic                  pend_q, pend_d;
   logic                  overrun_q, overrun_d;
   logic                  grant_smp_s;

   // The buffered sample is granted whenever the arbiter is idle and a word is pending.
   assign grant_smp_s = (state_q == S_IDLE) && pend_q;

   // Single-entry sample buffer with overwrite detection.
   always_comb begin
      sbuf_d    = sbuf_q;
      pend_d    = pend_q;
      overrun_d = 1'b0;
      if (sample_valid) begin
         // A capture in the grant cycle refills the buffer; the granted word is the old one.
         sbuf_d    = sample_data;
         pend_d    = 1'b1;
         overrun_d = pend_q & ~grant_smp_s;
      end else if (grant_smp_s) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   // Arbitration and CS/SPI sequencing: next state and registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cs_d        = cs_q;
      spi_start_d = 1'b0;
      spi_data_d  = spi_data_q;
      reg_ack_d   = 1'b0;
      timeout_d   = 1'b0;
      is_reg_d    = is_reg_q;
      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_d    = S_SETUP;
               cs_d       = CS_DAC;
               cnt_d      = SETUP_LD;
               spi_data_d = sbuf_q;
               is_reg_d   = 1'b0;
            end else if (reg_req && !sample_valid) begin
               // A sample arriving this cycle still wins: defer the register write.
               state_d    = S_SETUP;
               cs_d       = CS_REG;
               cnt_d      = SETUP_LD;
               spi_data_d = reg_data;
               is_reg_d   = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            // The start is issued on the edge leaving the last setup cycle so CS
            // leads spi_start by exactly CS_SETUP cycles.
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (!spi_busy) begin
               spi_start_d = 1'b1;
               cnt_d       = 8'd0;
               state_d     = S_WAIT;
            end else begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (!spi_busy) begin
               spi_start_d = 1'b1;
               cnt_d       = 8'd0;
               state_d     = S_WAIT;
            end else begin
               state_d = S_START;
            end
         end
         S_WAIT: begin
            // cnt_q holds the number of cycles elapsed since the start pulse.
            if (spi_done) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
            end else if (cnt_q >= TIMEOUT_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_HOLD;
               cnt_d     = HOLD_LD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d   = S_GAP;
               cs_d      = CS_NONE;
               cnt_d     = GAP_LD;
               reg_ack_d = is_reg_q;
            end
         end
         S_GAP: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cs_d    = CS_NONE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign arb_busy_d = (state_d != S_IDLE);

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         cs_q        <= CS_NONE;
         spi_start_q <= 1'b0;
         spi_data_q  <= '0;
         reg_ack_q   <= 1'b0;
         timeout_q   <= 1'b0;
         is_reg_q    <= 1'b0;
         arb_busy_q  <= 1'b0;
         sbuf_q      <= '0;
         pend_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cs_q        <= cs_d;
         spi_start_q <= spi_start_d;
         spi_data_q  <= spi_data_d;
         reg_ack_q   <= reg_ack_d;
         timeout_q   <= timeout_d;
         is_reg_q    <= is_reg_d;
         arb_busy_q  <= arb_busy_d;
         sbuf_q      <= sbuf_d;
         pend_q      <= pend_d;
         overrun_q   <= overrun_d;
      end
   end

   assign sample_overrun = overrun_q;
   assign reg_ack        = reg_ack_q;
   assign spi_start      = spi_start_q;
   assign spi_data       = spi_data_q;
   assign cs_dac_reg     = cs_q;
   assign arb_busy       = arb_busy_q;
   assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_dac_reg_spi_arbiter.sv
// Directed testbench for dac_reg_spi_arbiter (default parameters).
module tb_dac_reg_spi_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_valid;
   logic [7:0] sample_data;
   logic       sample_overrun;
   logic       reg_req;
   logic [7:0] reg_data;
   logic       reg_ack;
   logic       spi_start;
   logic [7:0] spi_data;
   logic       spi_busy;
   logic       spi_done;
   logic [1:0] cs_dac_reg;
   logic       arb_busy;
   logic       timeout_err;

   int errors = 0;
   int checks = 0;
   logic early;

   always #5 clk = ~clk;

   dac_reg_spi_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .sample_valid  (sample_valid),
      .sample_data   (sample_data),
      .sample_overrun(sample_overrun),
      .reg_req       (reg_req),
      .reg_data      (reg_data),
      .reg_ack       (reg_ack),
      .spi_start     (spi_start),
      .spi_data      (spi_data),
      .spi_busy      (spi_busy),
      .spi_done      (spi_done),
      .cs_dac_reg    (cs_dac_reg),
      .arb_busy      (arb_busy),
      .timeout_err   (timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; sample_valid = 1'b0; sample_data = 8'h00;
      reg_req = 1'b0; reg_data = 8'h00; spi_busy = 1'b0; spi_done = 1'b0;
      tick(); tick();
      chk("rst_cs", {30'd0, cs_dac_reg}, 32'h3);
      chk("rst_start", {31'd0, spi_start}, 32'h0);
      chk("rst_data", {24'd0, spi_data}, 32'h0);
      chk("rst_busy", {31'd0, arb_busy}, 32'h0);
      chk("rst_ack", {31'd0, reg_ack}, 32'h0);
      chk("rst_ovr", {31'd0, sample_overrun}, 32'h0);
      chk("rst_to", {31'd0, timeout_err}, 32'h0);
      rst = 1'b0;
      tick();

      // ---- single DAC sample A5 ----
      sample_valid = 1'b1; sample_data = 8'hA5;
      tick();                               // capture
      sample_valid = 1'b0;
      chk("t1_cs_pend", {30'd0, cs_dac_reg}, 32'h3);
      tick();                               // grant
      chk("t1_cs_grant", {30'd0, cs_dac_reg}, 32'h1);
      chk("t1_busy", {31'd0, arb_busy}, 32'h1);
      chk("t1_nostart0", {31'd0, spi_start}, 32'h0);
      tick();
      chk("t1_nostart1", {31'd0, spi_start}, 32'h0);
      tick();
      chk("t1_start", {31'd0, spi_start}, 32'h1);
      chk("t1_data", {24'd0, spi_data}, 32'hA5);
      chk("t1_cs_start", {30'd0, cs_dac_reg}, 32'h1);
      tick();
      chk("t1_start_once", {31'd0, spi_start}, 32'h0);
      repeat (8) tick();
      spi_done = 1'b1;
      tick();                               // done seen -> HOLD
      spi_done = 1'b0;
      chk("t1_cs_hold", {30'd0, cs_dac_reg}, 32'h1);
      tick();                               // GAP
      chk("t1_cs_gap", {30'd0, cs_dac_reg}, 32'h3);
      chk("t1_noack", {31'd0, reg_ack}, 32'h0);
      chk("t1_busy_gap", {31'd0, arb_busy}, 32'h1);
      tick();
      chk("t1_idle", {31'd0, arb_busy}, 32'h0);

      // ---- register write 3C ----
      reg_req = 1'b1; reg_data = 8'h3C;
      tick();
      chk("t2_cs", {30'd0, cs_dac_reg}, 32'h2);
      chk("t2_data", {24'd0, spi_data}, 32'h3C);
      tick(); tick();
      chk("t2_start", {31'd0, spi_start}, 32'h1);
      tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("t2_cs_hold", {30'd0, cs_dac_reg}, 32'h2);
      chk("t2_ack_early", {31'd0, reg_ack}, 32'h0);
      tick();
      chk("t2_cs_none", {30'd0, cs_dac_reg}, 32'h3);
      chk("t2_ack", {31'd0, reg_ack}, 32'h1);
      reg_req = 1'b0;
      tick();
      chk("t2_ack_once", {31'd0, reg_ack}, 32'h0);
      chk("t2_idle", {31'd0, arb_busy}, 32'h0);

      // ---- simultaneous sample 11 and register 5A ----
      reg_req = 1'b1; reg_data = 8'h5A;
      sample_valid = 1'b1; sample_data = 8'h11;
      tick();
      sample_valid = 1'b0;
      chk("t3_wait_cs", {30'd0, cs_dac_reg}, 32'h3);
      tick();
      chk("t3_dac_first", {30'd0, cs_dac_reg}, 32'h1);
      chk("t3_dac_data", {24'd0, spi_data}, 32'h11);
      tick(); tick();
      chk("t3_dac_start", {31'd0, spi_start}, 32'h1);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick();
      chk("t3_gap_cs", {30'd0, cs_dac_reg}, 32'h3);
      chk("t3_gap_noack", {31'd0, reg_ack}, 32'h0);
      tick();
      chk("t3_idle_cs", {30'd0, cs_dac_reg}, 32'h3);
      tick();
      chk("t3_reg_cs", {30'd0, cs_dac_reg}, 32'h2);
      chk("t3_reg_data", {24'd0, spi_data}, 32'h5A);
      tick(); tick();
      chk("t3_reg_start", {31'd0, spi_start}, 32'h1);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick();
      chk("t3_ack", {31'd0, reg_ack}, 32'h1);
      reg_req = 1'b0;
      tick();
      chk("t3_ack_once", {31'd0, reg_ack}, 32'h0);

      // ---- overrun while a transfer is in WAIT ----
      sample_valid = 1'b1; sample_data = 8'h77;
      tick();
      sample_valid = 1'b0;
      tick(); tick(); tick();
      chk("t4_start", {31'd0, spi_start}, 32'h1);
      sample_valid = 1'b1; sample_data = 8'h01;
      tick();
      chk("t4_no_ovr", {31'd0, sample_overrun}, 32'h0);
      sample_data = 8'h02;
      tick();
      sample_valid = 1'b0;
      chk("t4_ovr", {31'd0, sample_overrun}, 32'h1);
      tick();
      chk("t4_ovr_once", {31'd0, sample_overrun}, 32'h0);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick(); tick(); tick();
      chk("t4_next_cs", {30'd0, cs_dac_reg}, 32'h1);
      chk("t4_next_data", {24'd0, spi_data}, 32'h02);
      tick(); tick();
      chk("t4_next_start", {31'd0, spi_start}, 32'h1);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick(); tick(); tick();
      chk("t4_no_regrant", {31'd0, arb_busy}, 32'h0);

      // ---- timeout on a register transfer ----
      reg_req = 1'b1; reg_data = 8'hC3;
      tick(); tick(); tick();
      chk("t5_start", {31'd0, spi_start}, 32'h1);
      early = 1'b0;
      repeat (254) begin
         tick();
         if (timeout_err) early = 1'b1;
      end
      chk("t5_not_early", {31'd0, early}, 32'h0);
      tick();
      chk("t5_timeout", {31'd0, timeout_err}, 32'h1);
      chk("t5_cs_hold", {30'd0, cs_dac_reg}, 32'h2);
      tick();
      chk("t5_to_once", {31'd0, timeout_err}, 32'h0);
      chk("t5_cs_none", {30'd0, cs_dac_reg}, 32'h3);
      chk("t5_ack", {31'd0, reg_ack}, 32'h1);
      reg_req = 1'b0;
      tick();
      chk("t5_idle", {31'd0, arb_busy}, 32'h0);

      // ---- reset during WAIT with a sample pending ----
      sample_valid = 1'b1; sample_data = 8'h66;
      tick();
      sample_valid = 1'b0;
      tick(); tick(); tick();
      chk("t6_start", {31'd0, spi_start}, 32'h1);
      sample_valid = 1'b1; sample_data = 8'h99;
      tick();
      sample_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_cs", {30'd0, cs_dac_reg}, 32'h3);
      chk("t6_start0", {31'd0, spi_start}, 32'h0);
      chk("t6_busy", {31'd0, arb_busy}, 32'h0);
      chk("t6_data", {24'd0, spi_data}, 32'h0);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("t6_done_ignored", {31'd0, reg_ack | timeout_err}, 32'h0);
      tick(); tick();
      chk("t6_buf_empty", {31'd0, arb_busy}, 32'h0);
      chk("t6_cs_none", {30'd0, cs_dac_reg}, 32'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
